// File: rtl/bug_pkg.sv
// Shared constants, state encoding and the per-axis step helper for the bug sprite position controller.
package bug_pkg;

  localparam int SCREEN_WIDTH  = 1024;
  localparam int SCREEN_HEIGHT = 768;
  localparam int BUG_WIDTH     = 54;
  localparam int BUG_HEIGHT    = 53;

  localparam logic [11:0] X_MAX = 12'(SCREEN_WIDTH - BUG_WIDTH);
  localparam logic [11:0] Y_MAX = 12'(SCREEN_HEIGHT - BUG_HEIGHT);
  localparam logic [11:0] X_C   = X_MAX / 12'd2;
  localparam logic [11:0] Y_C   = Y_MAX / 12'd2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HIT  = 2'd2
  } bug_state_e;

  typedef struct packed {
    logic [11:0] pos;
    logic        neg;  // 1 = moving toward 0
  } axis_t;

  // One frame step on one axis. The 13-bit signed sum lets an underflow
  // below 0 be seen before it wraps.
  function automatic axis_t axis_step(input logic [11:0] pos, input logic neg,
                                      input logic [5:0] step, input logic [11:0] lim);
    logic signed [12:0] nx;
    axis_t r;
    nx = neg ? $signed({1'b0, pos}) - $signed({7'b0, step})
             : $signed({1'b0, pos}) + $signed({7'b0, step});
    r.pos = nx[11:0];
    r.neg = neg;
    if (nx >= $signed({1'b0, lim})) begin
      r.pos = lim;
      r.neg = 1'b1;
    end else if (nx <= 13'sd0) begin
      r.pos = '0;
      r.neg = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/bug_lfsr.sv
// 16-bit Galois LFSR (taps 16,14,13,11) advancing every pclk; used for random respawn points.
module bug_lfsr (
  input  logic        pclk,
  input  logic        reset,
  output logic [15:0] out
);

  logic [15:0] r_lfsr;

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) r_lfsr <= 16'hACE1;
    else        r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
  end

  assign out = r_lfsr;

endmodule

// File: rtl/bug_pos_ctl.sv
// Per-frame bug sprite position controller: diagonal motion with edge bounce, start/stop/hit handling.
// Optional build macro BUG_RANDOM_RESPAWN_EN selects LFSR-based respawn instead of recentring.
module bug_pos_ctl
  import bug_pkg::*;
#(
  parameter int STEP       = 2,
  parameter int HIT_FRAMES = 30
) (
  input  logic        pclk,
  input  logic        reset,
  input  logic        vblnk_in,
  input  logic        start,
  input  logic        stop,
  input  logic        hit,
  output logic [11:0] x_bugpos,
  output logic [11:0] y_bugpos,
  output logic        moving,
  output logic [7:0]  hit_count,
  output bug_state_e  dbg_state
);

  localparam logic [5:0] STEP_W = STEP[5:0];
  localparam logic [7:0] HIT_W  = HIT_FRAMES[7:0];

  bug_state_e  r_state, w_state;
  logic [11:0] r_x, r_y, w_x, w_y;
  logic        r_dx, r_dy, w_dx, w_dy;
  logic [7:0]  r_frz, w_frz;
  logic [7:0]  r_hits, w_hits;
  logic        r_moving, w_moving;
  logic        r_vblnk_q;
  logic        w_tick;
  logic [11:0] w_rsp_x, w_rsp_y;
  axis_t       w_ax, w_ay;

`ifdef BUG_RANDOM_RESPAWN_EN
  logic [15:0] w_rnd;
  logic [11:0] w_rnd_x, w_rnd_y;

  bug_lfsr u_lfsr (
    .pclk  (pclk),
    .reset (reset),
    .out   (w_rnd)
  );

  // Folding the 10-bit draw back by the limit keeps every respawn on screen.
  assign w_rnd_x = {2'b00, w_rnd[9:0]};
  assign w_rnd_y = {2'b00, w_rnd[15:6]};
  assign w_rsp_x = (w_rnd_x > X_MAX) ? (w_rnd_x - X_MAX) : w_rnd_x;
  assign w_rsp_y = (w_rnd_y > Y_MAX) ? (w_rnd_y - Y_MAX) : w_rnd_y;
`else
  assign w_rsp_x = X_C;
  assign w_rsp_y = Y_C;
`endif

  assign w_tick = vblnk_in & ~r_vblnk_q;
  assign w_ax   = axis_step(r_x, r_dx, STEP_W, X_MAX);
  assign w_ay   = axis_step(r_y, r_dy, STEP_W, Y_MAX);

  always_ff @(posedge pclk or negedge reset) begin
    if (!reset) begin
      r_state   <= IDLE;
      r_x       <= X_C;
      r_y       <= Y_C;
      r_dx      <= 1'b0;
      r_dy      <= 1'b0;
      r_frz     <= '0;
      r_hits    <= '0;
      r_moving  <= 1'b0;
      r_vblnk_q <= 1'b0;
    end else begin
      r_state   <= w_state;
      r_x       <= w_x;
      r_y       <= w_y;
      r_dx      <= w_dx;
      r_dy      <= w_dy;
      r_frz     <= w_frz;
      r_hits    <= w_hits;
      r_moving  <= w_moving;
      r_vblnk_q <= vblnk_in;
    end
  end

  // Event priority is stop > hit > start > tick; a tick lost to a higher event is not replayed.
  always_comb begin
    w_state = r_state;
    w_x     = r_x;
    w_y     = r_y;
    w_dx    = r_dx;
    w_dy    = r_dy;
    w_frz   = r_frz;
    w_hits  = r_hits;
    case (r_state)
      IDLE: begin
        if (stop) begin
          w_x = X_C;
          w_y = Y_C;
        end else if (start) begin
          w_state = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          w_state = IDLE;
          w_x     = X_C;
          w_y     = Y_C;
        end else if (hit) begin
          w_state = HIT;
          w_frz   = HIT_W;
          if (r_hits != 8'hFF) w_hits = r_hits + 8'd1;
        end else if (w_tick) begin
          w_x  = w_ax.pos;
          w_dx = w_ax.neg;
          w_y  = w_ay.pos;
          w_dy = w_ay.neg;
        end
      end
      HIT: begin
        if (stop) begin
          w_state = IDLE;
          w_x     = X_C;
          w_y     = Y_C;
          w_frz   = '0;
        end else if (w_tick) begin
          if (r_frz <= 8'd1) begin
            w_state = RUN;
            w_frz   = '0;
            w_x     = w_rsp_x;
            w_y     = w_rsp_y;
            w_dx    = ~r_dx;
            w_dy    = ~r_dy;
          end else begin
            w_frz = r_frz - 8'd1;
          end
        end
      end
      default: w_state = IDLE;
    endcase
    w_moving = (w_state == RUN);
  end

  assign x_bugpos  = r_x;
  assign y_bugpos  = r_y;
  assign moving    = r_moving;
  assign hit_count = r_hits;
  assign dbg_state = r_state;

endmodule
